audio_ram_player: RTL and testbench
===================================

AUDIO_RAM_PLAYER -- requirements
Module: audio_ram_player

Interface
REQ-001 Parameters SHALL be: ADDR_W, 12, RAM word-address width; DATA_W, 32, RAM word width (upper 16 bits left, lower 16 bits right).
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  one-cycle pulse; begins playback.
REQ-005 stop  input  1  one-cycle pulse; aborts playback.
REQ-006 loop_en  input  1  wrap from end_addr back to start_addr.
REQ-007 start_addr  input  ADDR_W  first word to play; latched on accepted start.
REQ-008 end_addr  input  ADDR_W  last word to play, inclusive; latched on accepted start.
REQ-009 ram_address  output  ADDR_W  read address to the RAM second port.
REQ-010 ram_chipselect  output  1  read strobe to the RAM second port.
REQ-011 ram_write  output  1  tied 0; this block never writes.
REQ-012 ram_byteenable  output  4  tied 4'hF.
REQ-013 ram_readdata  input  DATA_W  RAM port data, valid exactly 1 cycle after the address is registered.
REQ-014 sample_left  output  16  left sample.
REQ-015 sample_right  output  16  right sample.
REQ-016 sample_valid  output  1  sample pair available.
REQ-017 sample_ready  input  1  sink accepts the pair on a cycle where valid and ready are both 1.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse when non-loop playback completes.

Function
REQ-020 The FSM SHALL have four states: IDLE, READ, CAPTURE and PRESENT.
REQ-021 IDLE: with start=1 and stop=0, latch start_addr/end_addr into internal regs, load cur_addr=start_addr, go to READ; otherwise remain in IDLE.
REQ-022 READ: drive ram_chipselect=1 and ram_address=cur_addr for exactly one cycle, then go to CAPTURE.
REQ-023 CAPTURE: ram_chipselect=0; at the closing edge load sample_left=ram_readdata[31:16] and sample_right=ram_readdata[15:0]; go to PRESENT.
REQ-024 PRESENT: hold sample_valid=1 and the sample regs stable until sample_ready=1.
REQ-025 On acceptance in PRESENT with cur_addr!=end_addr: cur_addr=cur_addr+1 modulo 2^ADDR_W (4095 wraps to 0), go to READ.
REQ-026 On acceptance in PRESENT with cur_addr==end_addr and loop_en=1: cur_addr=latched start_addr, go to READ, no done pulse.
REQ-027 On acceptance in PRESENT with cur_addr==end_addr and loop_en=0: done=1 for the next cycle only, go to IDLE.
REQ-028 loop_en SHALL be sampled live at the end-address acceptance cycle, not latched.
REQ-029 end_addr < start_addr SHALL be legal: playback runs start_addr..4095, 0..end_addr.
REQ-030 end_addr == start_addr SHALL play exactly one word per pass.
REQ-031 Latency SHALL be: start pulse at cycle N -> ram_chipselect at N+1 -> sample_valid at N+3; minimum period is 3 cycles per accepted sample.
REQ-032 stop=1 in any non-IDLE state SHALL force IDLE next cycle, with sample_valid=0 and ram_chipselect=0 from that cycle; done SHALL NOT pulse.
REQ-033 stop and start asserted in the same cycle SHALL resolve as stop (remain or return to IDLE).
REQ-034 start while busy SHALL be ignored; latched config SHALL be unchanged.
REQ-035 A stop in the same cycle as a final acceptance SHALL take priority: go to IDLE with no done pulse.
REQ-036 sample_valid SHALL be 1 only in PRESENT.

Reset
REQ-037 reset_n=0 SHALL asynchronously force: state IDLE, cur_addr=0, latched addrs=0, sample_left=0, sample_right=0, sample_valid=0, ram_chipselect=0, ram_address=0, busy=0, done=0.
REQ-038 Reset deassertion SHALL be synchronous to clk; the first start is accepted on the first edge after release.
REQ-039 Reset mid-playback SHALL discard the in-flight read with no done pulse.

Verification
REQ-040 Linear play: start_addr=10, end_addr=12, loop_en=0, ready=1, RAM[10..12]=0x11112222/0x33334444/0x55556666 -> 3 pairs (1111,2222),(3333,4444),(5555,6666) in order, samples 3 cycles apart, done one cycle after the third acceptance, busy=0 afterwards.
REQ-041 Backpressure: hold sample_ready=0 for 5 cycles in PRESENT -> sample_valid and data stable throughout, no extra ram_chipselect pulses.
REQ-042 Wrap: start_addr=4094, end_addr=1 -> ram_address sequence 4094, 4095, 0, 1 -> done.
REQ-043 Loop: start_addr=end_addr=7, loop_en=1 for 3 acceptances, then 0 -> address 7 read 4 times, done after the 4th acceptance.
REQ-044 Stop/priority: stop during CAPTURE -> IDLE next cycle, sample_valid never rises, no done; start+stop in IDLE -> stays IDLE; start during PRESENT -> ignored.
REQ-045 Async reset: assert reset_n=0 mid-PRESENT between clock edges -> all outputs at reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/audio_ram_player_if.sv
`default_nettype none
// ============================================================================
//  Module   : audio_ram_player_if
//  Brief    : Control, RAM read-port and sample-stream signals of the
//             audio RAM player, grouped with player-side (slave) and
//             controller/environment-side (master) views.
//  Revision : 1.0 - initial release
// ============================================================================
interface audio_ram_player_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect;
    logic              ram_write;
    logic [3:0]        ram_byteenable;
    logic [DATA_W-1:0] ram_readdata;
    logic [15:0]       sample_left;
    logic [15:0]       sample_right;
    logic              sample_valid;
    logic              sample_ready;
    logic              busy;
    logic              done;

    modport slave (
        input  start, stop, loop_en, start_addr, end_addr, ram_readdata, sample_ready,
        output ram_address, ram_chipselect, ram_write, ram_byteenable,
               sample_left, sample_right, sample_valid, busy, done
    );

    modport master (
        output start, stop, loop_en, start_addr, end_addr, ram_readdata, sample_ready,
        input  ram_address, ram_chipselect, ram_write, ram_byteenable,
               sample_left, sample_right, sample_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/audio_ram_player.sv
`default_nettype none
// ============================================================================
//  Module   : audio_ram_player
//  Brief    : Streams stereo sample pairs out of a RAM read port, from a
//             start word to an end word (inclusive, address-wrapping), with
//             optional looping, stop abort and ready/valid backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_ram_player #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    audio_ram_player_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_CAPTURE = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [ADDR_W-1:0] end_addr_q, end_addr_d;
    logic [15:0]       left_q, left_d;
    logic [15:0]       right_q, right_d;
    logic              done_q, done_d;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            left_q       <= '0;
            right_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            start_addr_q <= start_addr_d;
            end_addr_q   <= end_addr_d;
            left_q       <= left_d;
            right_q      <= right_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic; stop wins over start and over the final acceptance.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        start_addr_d = start_addr_q;
        end_addr_d   = end_addr_q;
        left_d       = left_q;
        right_d      = right_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    start_addr_d = bus.start_addr;
                    end_addr_d   = bus.end_addr;
                    cur_addr_d   = bus.start_addr;
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                state_d = bus.stop ? S_IDLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else begin
                    left_d  = bus.ram_readdata[DATA_W-1:DATA_W-16];
                    right_d = bus.ram_readdata[15:0];
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (bus.sample_ready) begin
                    if (cur_addr_q != end_addr_q) begin
                        // Natural ADDR_W overflow gives the top-to-zero wrap.
                        cur_addr_d = cur_addr_q + ADDR_W'(1);
                        state_d    = S_READ;
                    end else if (bus.loop_en) begin
                        cur_addr_d = start_addr_q;
                        state_d    = S_READ;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode directly from registered state so reset acts at once.
    always_comb begin
        bus.ram_address    = cur_addr_q;
        bus.ram_chipselect = (state_q == S_READ);
        bus.ram_write      = 1'b0;
        bus.ram_byteenable = 4'hF;
        bus.sample_left    = left_q;
        bus.sample_right   = right_q;
        bus.sample_valid   = (state_q == S_PRESENT);
        bus.busy           = (state_q != S_IDLE);
        bus.done           = done_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_ram_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_ram_player
//  Brief    : Directed self-checking bench for audio_ram_player with a
//             one-cycle-latency RAM model on the read port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_ram_player;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    logic [31:0] mem [0:4095];
    logic [31:0] rd_q;

    audio_ram_player_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    audio_ram_player #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read port: address registered on the edge, data valid the next cycle.
    always @(posedge clk) begin
        if (bus.ram_chipselect) rd_q <= mem[bus.ram_address];
    end
    assign bus.ram_readdata = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the edge that entered READ; returns in PRESENT.
    task automatic read_word(input string tag, input logic [11:0] a, input logic [31:0] d);
        chk({tag, "_cs"}, 32'(bus.ram_chipselect), 32'd1);
        chk({tag, "_addr"}, 32'(bus.ram_address), 32'(a));
        tick();
        chk({tag, "_cs_off"}, 32'(bus.ram_chipselect), 32'd0);
        chk({tag, "_early_valid"}, 32'(bus.sample_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(bus.sample_valid), 32'd1);
        chk({tag, "_left"}, 32'(bus.sample_left), 32'(d[31:16]));
        chk({tag, "_right"}, 32'(bus.sample_right), 32'(d[15:0]));
    endtask

    task automatic start_play(input logic [11:0] sa, input logic [11:0] ea);
        bus.start_addr = sa;
        bus.end_addr   = ea;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs"}, 32'(bus.ram_chipselect), 32'd0);
        chk({tag, "_addr"}, 32'(bus.ram_address), 32'd0);
        chk({tag, "_valid"}, 32'(bus.sample_valid), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_left"}, 32'(bus.sample_left), 32'd0);
        chk({tag, "_right"}, 32'(bus.sample_right), 32'd0);
    endtask

    initial begin
        logic [11:0] wrap_a [4];
        logic [31:0] wrap_d [4];
        logic [11:0] lin_a  [3];
        logic [31:0] lin_d  [3];

        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hDEAD_BEEF;
        mem[10]   = 32'h1111_2222;
        mem[11]   = 32'h3333_4444;
        mem[12]   = 32'h5555_6666;
        mem[20]   = 32'h2020_0020;
        mem[4094] = 32'hFFE0_1FFE;
        mem[4095] = 32'hFFF0_2FFF;
        mem[0]    = 32'h0000_3000;
        mem[1]    = 32'h0001_3001;
        mem[7]    = 32'h7777_0007;
        mem[40]   = 32'h4040_0040;
        mem[41]   = 32'h4141_0041;
        mem[50]   = 32'h5050_0050;
        mem[60]   = 32'h6060_0060;
        rd_q      = 32'h0;

        reset_n          = 1'b0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.loop_en      = 1'b0;
        bus.start_addr   = '0;
        bus.end_addr     = '0;
        bus.sample_ready = 1'b1;

        // Reset state, checked before any clock edge.
        #1;
        chk_reset_outputs("rst");
        chk("rst_write", 32'(bus.ram_write), 32'd0);
        chk("rst_be", 32'(bus.ram_byteenable), 32'hF);

        // Linear play 10..12; start is accepted on the first edge after release.
        @(negedge clk);
        reset_n = 1'b1;
        lin_a = '{12'd10, 12'd11, 12'd12};
        lin_d = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
        start_play(12'd10, 12'd12);
        chk("lin_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            read_word($sformatf("lin%0d", i), lin_a[i], lin_d[i]);
            chk($sformatf("lin%0d_nodone", i), 32'(bus.done), 32'd0);
            tick();
        end
        chk("lin_done", 32'(bus.done), 32'd1);
        chk("lin_idle", 32'(bus.busy), 32'd0);
        chk("lin_valid_off", 32'(bus.sample_valid), 32'd0);
        tick();
        chk("lin_done_pulse", 32'(bus.done), 32'd0);

        // Backpressure: ready low for 5 cycles in PRESENT.
        bus.sample_ready = 1'b0;
        start_play(12'd20, 12'd20);
        read_word("bp", 12'd20, 32'h2020_0020);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp%0d_valid", i), 32'(bus.sample_valid), 32'd1);
            chk($sformatf("bp%0d_left", i), 32'(bus.sample_left), 32'h2020);
            chk($sformatf("bp%0d_right", i), 32'(bus.sample_right), 32'h0020);
            chk($sformatf("bp%0d_cs", i), 32'(bus.ram_chipselect), 32'd0);
        end
        bus.sample_ready = 1'b1;
        tick();
        chk("bp_done", 32'(bus.done), 32'd1);
        tick();

        // Address wrap 4094..1.
        wrap_a = '{12'd4094, 12'd4095, 12'd0, 12'd1};
        wrap_d = '{32'hFFE0_1FFE, 32'hFFF0_2FFF, 32'h0000_3000, 32'h0001_3001};
        start_play(12'd4094, 12'd1);
        for (int i = 0; i < 4; i++) begin
            read_word($sformatf("wrap%0d", i), wrap_a[i], wrap_d[i]);
            tick();
        end
        chk("wrap_done", 32'(bus.done), 32'd1);
        chk("wrap_idle", 32'(bus.busy), 32'd0);
        tick();

        // Loop on a single word: loop_en high for 3 acceptances, then low.
        start_play(12'd7, 12'd7);
        for (int i = 0; i < 4; i++) begin
            read_word($sformatf("loop%0d", i), 12'd7, 32'h7777_0007);
            bus.loop_en = (i < 3);
            tick();
            if (i < 3) chk($sformatf("loop%0d_nodone", i), 32'(bus.done), 32'd0);
        end
        bus.loop_en = 1'b0;
        chk("loop_done", 32'(bus.done), 32'd1);
        chk("loop_idle", 32'(bus.busy), 32'd0);
        tick();

        // Stop during CAPTURE.
        start_play(12'd30, 12'd35);
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stopc_busy", 32'(bus.busy), 32'd0);
        chk("stopc_cs", 32'(bus.ram_chipselect), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stopc%0d_valid", i), 32'(bus.sample_valid), 32'd0);
            chk($sformatf("stopc%0d_done", i), 32'(bus.done), 32'd0);
            tick();
        end

        // Start and stop together in IDLE stays IDLE.
        bus.stop = 1'b1;
        start_play(12'd30, 12'd35);
        bus.stop = 1'b0;
        chk("ss_busy", 32'(bus.busy), 32'd0);
        chk("ss_cs", 32'(bus.ram_chipselect), 32'd0);

        // Start while PRESENT is ignored; original config keeps running.
        bus.sample_ready = 1'b0;
        start_play(12'd40, 12'd41);
        read_word("ign", 12'd40, 32'h4040_0040);
        start_play(12'd100, 12'd100);
        chk("ign_valid", 32'(bus.sample_valid), 32'd1);
        chk("ign_cs", 32'(bus.ram_chipselect), 32'd0);
        chk("ign_left", 32'(bus.sample_left), 32'h4040);
        bus.sample_ready = 1'b1;
        tick();
        read_word("ign2", 12'd41, 32'h4141_0041);
        tick();
        chk("ign_done", 32'(bus.done), 32'd1);
        tick();

        // Stop coinciding with the final acceptance: no done.
        start_play(12'd50, 12'd50);
        read_word("sf", 12'd50, 32'h5050_0050);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("sf_done", 32'(bus.done), 32'd0);
        chk("sf_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("sf_done2", 32'(bus.done), 32'd0);

        // Asynchronous reset between edges while in PRESENT.
        bus.sample_ready = 1'b0;
        start_play(12'd60, 12'd60);
        read_word("ar", 12'd60, 32'h6060_0060);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("ar_rst");
        @(negedge clk);
        reset_n = 1'b1;
        bus.sample_ready = 1'b1;
        start_play(12'd60, 12'd60);
        read_word("ar_post", 12'd60, 32'h6060_0060);
        tick();
        chk("ar_post_done", 32'(bus.done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
